// File: rtl/l2_bank_pkg.sv
// ----------------------------------------------------------------------------
// l2_bank_pkg
// Shared types and constants for the L2 bank adapter slice.
//   - resp_entry_t : one slot of the response pipeline {valid, id, is_read, err}
//   - OPC_OK/OPC_ERR : response opcode values
//   - ERR_CNT_WIDTH : width of the saturating address-error counter
//   - sat_inc() : saturating increment used by the error counter
// ----------------------------------------------------------------------------
package l2_bank_pkg;

  localparam int unsigned ERR_CNT_WIDTH = 16;

  // Requester ID width carried through the response pipeline.
  localparam int unsigned RESP_ID_WIDTH = 16;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  typedef struct packed {
    logic                     valid;
    logic [RESP_ID_WIDTH-1:0] id;
    logic                     is_read;
    logic                     err;
  } resp_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l2_bank_adapter_if.sv
// ----------------------------------------------------------------------------
// l2_bank_adapter_if
// Request/response bus between the single-channel L2 request block and the
// bank adapter.
//   Request : data_req_i, data_add_i, data_wen_i, data_wdata_i, data_wtag_i,
//             data_be_i, data_ID_i  ->  data_gnt_o
//   Response: data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_rtag_o,
//             data_r_opc_o
//
// Handshake: a request transfers on the rising clock edge where data_req_i
// and data_gnt_o are both 1. data_gnt_o is combinational from data_req_i, so
// the requester holds data_req_i and all request fields stable until it sees
// the grant. The response channel has no backpressure: data_r_valid_o is a
// one-cycle pulse per accepted request, delivered in acceptance order, and
// the response fields are meaningful only in that cycle.
//
// modport master : the request block side
// modport slave  : the bank adapter side
// ----------------------------------------------------------------------------
interface l2_bank_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TAG_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 16
);

  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_wen_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [TAG_WIDTH-1:0]  data_wtag_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_o;

  logic                  data_r_valid_o;
  logic [ID_WIDTH-1:0]   data_r_ID_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic [TAG_WIDTH-1:0]  data_r_rtag_o;
  logic                  data_r_opc_o;

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_wtag_i,
           data_be_i, data_ID_i,
    input  data_gnt_o,
    input  data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_rtag_o,
           data_r_opc_o
  );

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_wtag_i,
           data_be_i, data_ID_i,
    output data_gnt_o,
    output data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_rtag_o,
           data_r_opc_o
  );

endinterface

// File: rtl/l2_resp_pipe.sv
// ----------------------------------------------------------------------------
// l2_resp_pipe
// DEPTH-stage shift register of response entries. An entry presented on
// in_entry in cycle T appears on out_entry in cycle T+DEPTH, lining up with
// the SRAM read data of the same access. Reset clears every stage, which
// drops any responses still in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_entry   : entry captured at the end of the current cycle
//   out_entry  : entry leaving the last stage
// ----------------------------------------------------------------------------
module l2_resp_pipe
  import l2_bank_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  resp_entry_t in_entry,
  output resp_entry_t out_entry
);

  resp_entry_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/l2_bank_adapter.sv
// ----------------------------------------------------------------------------
// l2_bank_adapter
// Drives one single-port L2 SRAM bank from the arbitrated request stream and
// returns one response per accepted request, MEM_LATENCY cycles later.
// Requests outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*BE_WIDTH) are accepted
// but do not touch the SRAM; they answer with OPC_ERR and bump err_cnt_o.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/grant and response channel
//   bank_stall_i    : bank busy this cycle; withholds the grant
//   mem_cen_o/wen_o : SRAM chip/write enables, active low
//   mem_add_o       : SRAM word address
//   mem_wdata_o/wtag_o/be_o : SRAM write data, tag, byte enables
//   mem_rdata_i/rtag_i      : SRAM read data/tag, MEM_LATENCY cycles after access
//   err_cnt_o       : saturating count of accepted out-of-range requests
// ----------------------------------------------------------------------------
module l2_bank_adapter
  import l2_bank_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned           TAG_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned           ID_WIDTH       = 16,
  parameter int unsigned           MEM_WORDS      = 8192,
  parameter int unsigned           MEM_ADDR_WIDTH = $clog2(MEM_WORDS),
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int                    MEM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  l2_bank_adapter_if.slave          bus,
  input  logic                      bank_stall_i,
  output logic                      mem_cen_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TAG_WIDTH-1:0]      mem_wtag_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic [TAG_WIDTH-1:0]      mem_rtag_i,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("l2_bank_adapter: MEM_LATENCY must be in 1..4");
  end

  if (ID_WIDTH != RESP_ID_WIDTH) begin : g_bad_id_width
    $error("l2_bank_adapter: ID_WIDTH must equal l2_bank_pkg::RESP_ID_WIDTH");
  end

  localparam int unsigned           OFF_SHIFT   = $clog2(BE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);

  // --------------------------------------------------------------------------
  // Address decode. The subtraction wraps, so addresses below BASE_ADDR are
  // caught by the explicit >= compare rather than by the index bound.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;

  assign off      = bus.data_add_i - BASE_ADDR;
  assign idx      = off >> OFF_SHIFT;
  assign in_range = (bus.data_add_i >= BASE_ADDR) && (idx < MEM_WORDS_A);

  // --------------------------------------------------------------------------
  // Grant and SRAM drive. No buffering: a granted in-range request goes
  // straight to the SRAM in the same cycle.
  // --------------------------------------------------------------------------
  logic gnt;
  logic mem_access;

  assign gnt            = bus.data_req_i & ~bank_stall_i;
  assign mem_access     = gnt & in_range;
  assign bus.data_gnt_o = gnt;

  always_comb begin
    mem_cen_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    mem_wtag_o  = '0;
    mem_be_o    = '0;
    if (mem_access) begin
      mem_cen_o   = 1'b0;
      mem_wen_o   = bus.data_wen_i;
      mem_add_o   = idx[MEM_ADDR_WIDTH-1:0];
      mem_wdata_o = bus.data_wdata_i;
      mem_wtag_o  = bus.data_wtag_i;
      mem_be_o    = bus.data_be_i;
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline. Every grant, in range or not, enters the pipe so the
  // requester always gets exactly one response per accepted request.
  // --------------------------------------------------------------------------
  resp_entry_t in_entry;
  resp_entry_t out_entry;

  always_comb begin
    in_entry = '0;
    if (gnt) begin
      in_entry.valid   = 1'b1;
      in_entry.id      = bus.data_ID_i;
      in_entry.is_read = bus.data_wen_i;
      in_entry.err     = ~in_range;
    end
  end

  l2_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_entry  (in_entry),
    .out_entry (out_entry)
  );

  // Response fields are zero outside a valid cycle; read data is forwarded
  // only for error-free reads since writes and rejected accesses leave the
  // SRAM outputs meaningless.
  always_comb begin
    bus.data_r_valid_o = out_entry.valid;
    bus.data_r_ID_o    = '0;
    bus.data_r_rdata_o = '0;
    bus.data_r_rtag_o  = '0;
    bus.data_r_opc_o   = OPC_OK;
    if (out_entry.valid) begin
      bus.data_r_ID_o  = out_entry.id;
      bus.data_r_opc_o = out_entry.err ? OPC_ERR : OPC_OK;
      if (out_entry.is_read && !out_entry.err) begin
        bus.data_r_rdata_o = mem_rdata_i;
        bus.data_r_rtag_o  = mem_rtag_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating address-error counter.
  // --------------------------------------------------------------------------
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (gnt && !in_range) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule
